// File: rtl/sfx_arbiter_if.sv
// sfx_arbiter_if: request/frame strobes in, audio/status out, for the sound-effect arbiter.
// The master modport belongs to the game logic; the slave modport belongs to the arbiter.
interface sfx_arbiter_if;
    logic       FRAME_TICK;
    logic [3:0] REQ;
    logic       AUDIO;
    logic       BUSY;
    logic [1:0] ACTIVE_ID;

    modport master (
        output FRAME_TICK,
        output REQ,
        input  AUDIO,
        input  BUSY,
        input  ACTIVE_ID
    );

    modport slave (
        input  FRAME_TICK,
        input  REQ,
        output AUDIO,
        output BUSY,
        output ACTIVE_ID
    );
endinterface

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: four-effect priority arbiter driving one square-wave audio bit.
// Requests are latched into a pending set.  The highest pending index is granted
// from IDLE, and its tone plays for DUR_FRAMES frames.  A GAP frame of silence
// follows before the next grant.
// Build option: define SFX_PREEMPT_EN to let a higher pending effect restart the
// tone during PLAY.  Without it, every tone runs to full length.
module sfx_arbiter #(
    parameter logic [15:0] HALF_0     = 16'd40000,
    parameter logic [15:0] HALF_1     = 16'd30000,
    parameter logic [15:0] HALF_2     = 16'd20000,
    parameter logic [15:0] HALF_3     = 16'd10000,
    parameter logic [7:0]  DUR_FRAMES = 8'd6
) (
    input  logic          CLK,
    input  logic          RESET_N,
    sfx_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // A half-period of 0 behaves like 1, so the tone toggles every cycle.
    function automatic logic [15:0] eff_half(input logic [15:0] h);
        return (h < 16'd2) ? 16'd1 : h;
    endfunction

    // Returns the highest set index. Callers only use it when v is nonzero.
    function automatic logic [1:0] top_index(input logic [3:0] v);
        logic [1:0] idx;
        if (v[3]) begin
            idx = 2'd3;
        end else if (v[2]) begin
            idx = 2'd2;
        end else if (v[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    localparam logic [15:0] H0 = eff_half(HALF_0);
    localparam logic [15:0] H1 = eff_half(HALF_1);
    localparam logic [15:0] H2 = eff_half(HALF_2);
    localparam logic [15:0] H3 = eff_half(HALF_3);

    logic [1:0]  state_q,   state_d;
    logic [3:0]  pending_q, pending_d;
    logic [15:0] div_q,     div_d;
    logic [7:0]  frames_q,  frames_d;
    logic        audio_q,   audio_d;
    logic        busy_q,    busy_d;
    logic [1:0]  active_q,  active_d;

    logic [15:0] half_s;
    logic        grant_s;
    logic [1:0]  grant_id_s;
    logic [3:0]  above_s;

    // Select the half-period of the effect that currently holds the grant.
    always_comb begin
        half_s = H0;
        case (active_q)
            2'd0:    half_s = H0;
            2'd1:    half_s = H1;
            2'd2:    half_s = H2;
            2'd3:    half_s = H3;
            default: half_s = H0;
        endcase
    end

    // Decide whether a grant happens this edge, and which effect receives it.
    // Only the registered pending set is considered, so a REQ arriving at the
    // grant edge waits for the next grant.
    always_comb begin
        grant_id_s = top_index(pending_q);
        above_s    = 4'b0000;
        case (active_q)
            2'd0:    above_s = 4'b1110;
            2'd1:    above_s = 4'b1100;
            2'd2:    above_s = 4'b1000;
            default: above_s = 4'b0000;
        endcase
        if (state_q == ST_IDLE) begin
            grant_s = (pending_q != 4'b0000);
        end else if (state_q == ST_PLAY) begin
`ifdef SFX_PREEMPT_EN
            grant_s = ((pending_q & above_s) != 4'b0000);
`else
            grant_s = 1'b0;
`endif
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic for the FSM, the tone divider and the pending set.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        frames_d = frames_q;
        audio_d  = audio_q;
        active_d = active_q;
        if (grant_s) begin
            pending_d = (pending_q & ~(4'b0001 << grant_id_s)) | bus.REQ;
        end else begin
            pending_d = pending_q | bus.REQ;
        end

        case (state_q)
            ST_IDLE, ST_PLAY: begin
                if (grant_s) begin
                    // A preempted effect is dropped, not re-queued.
                    state_d  = ST_PLAY;
                    active_d = grant_id_s;
                    div_d    = 16'd0;
                    audio_d  = 1'b0;
                    frames_d = DUR_FRAMES;
                end else if (state_q == ST_IDLE) begin
                    state_d = ST_IDLE;
                end else if (bus.FRAME_TICK && (frames_q == 8'd1)) begin
                    state_d = ST_GAP;
                    div_d   = 16'd0;
                    audio_d = 1'b0;
                end else begin
                    if (bus.FRAME_TICK) begin
                        frames_d = frames_q - 8'd1;
                    end else begin
                        frames_d = frames_q;
                    end
                    if (div_q >= (half_s - 16'd1)) begin
                        div_d   = 16'd0;
                        audio_d = ~audio_q;
                    end else begin
                        div_d = div_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                audio_d = 1'b0;
                if (bus.FRAME_TICK) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                audio_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. The reset is synchronous and overrides REQ and FRAME_TICK.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            div_q     <= 16'd0;
            frames_q  <= 8'd0;
            audio_q   <= 1'b0;
            busy_q    <= 1'b0;
            active_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            frames_q  <= frames_d;
            audio_q   <= audio_d;
            busy_q    <= busy_d;
            active_q  <= active_d;
        end
    end

    assign bus.AUDIO     = audio_q;
    assign bus.BUSY      = busy_q;
    assign bus.ACTIVE_ID = active_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: directed bench for sfx_arbiter with HALF = 8,6,4,2 and DUR_FRAMES = 2.
// FRAME_TICK pulses once every 100 cycles. Expected values are computed by hand.
// The bench follows SFX_PREEMPT_EN so that it matches either build.
module tb_sfx_arbiter;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    sfx_arbiter_if bus();

    sfx_arbiter #(
        .HALF_0     (16'd8),
        .HALF_1     (16'd6),
        .HALF_2     (16'd4),
        .HALF_3     (16'd2),
        .DUR_FRAMES (8'd2)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    // 100 MHz-style free-running clock; only relative timing matters here.
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int fcnt  = 0;
    int ticks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: present FRAME_TICK, take the edge, sample 1 ns later, clear the pulses.
    task automatic step();
        bus.FRAME_TICK = (fcnt == 99);
        @(posedge CLK);
        #1;
        if (bus.FRAME_TICK) ticks++;
        fcnt = (fcnt == 99) ? 0 : fcnt + 1;
        bus.REQ        = 4'b0000;
        bus.FRAME_TICK = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ticks(input int target);
        int guard = 0;
        while (ticks < target && guard < 1000) begin
            step();
            guard++;
        end
        check_val("tick_wait", ticks >= target, 1);
    endtask

    // Counts the clocks until AUDIO changes level, with an upper bound.
    task automatic measure(output int n);
        logic a0;
        a0 = bus.AUDIO;
        n  = 0;
        while (bus.AUDIO === a0 && n < 300) begin
            step();
            n++;
        end
    endtask

    // Runs until the current tone leaves GAP (grant base + 3 ticks) and checks for idle.
    task automatic finish_tone(input string tag, input int base);
        wait_ticks(base + 2);
        check_val({tag, "_gap_busy"}, bus.BUSY, 1);
        check_val({tag, "_gap_audio"}, bus.AUDIO, 0);
        wait_ticks(base + 3);
        check_val({tag, "_idle_busy"}, bus.BUSY, 0);
    endtask

    initial begin
        int n;
        int base;
        int cnt;
        bus.REQ        = 4'b0000;
        bus.FRAME_TICK = 1'b0;

        // Reset. REQ held high while in reset must be ignored.
        RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.REQ = 4'b1111;
            step();
        end
        check_val("rst_audio", bus.AUDIO, 0);
        check_val("rst_busy", bus.BUSY, 0);
        check_val("rst_active", bus.ACTIVE_ID, 0);
        RESET_N = 1'b1;
        steps(3);
        check_val("rst_noreq_busy", bus.BUSY, 0);

        // Single effect 0: check grant latency, half period 8, then GAP and IDLE.
        bus.REQ = 4'b0001;
        step();
        check_val("a_lat_k", bus.BUSY, 0);
        step();
        check_val("a_lat_k1", bus.BUSY, 1);
        check_val("a_active", bus.ACTIVE_ID, 0);
        check_val("a_audio0", bus.AUDIO, 0);
        base = ticks;
        measure(n); check_val("a_half1", n, 8);
        measure(n); check_val("a_half2", n, 8);
        wait_ticks(base + 2);
        check_val("a_gap_busy", bus.BUSY, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.AUDIO !== 1'b0) cnt++;
        end
        check_val("a_gap_quiet", cnt, 0);
        wait_ticks(base + 3);
        check_val("a_idle_busy", bus.BUSY, 0);

        // REQ 1010: effect 3 (half 2) first, then effect 1 (half 6), then nothing.
        bus.REQ = 4'b1010;
        step();
        step();
        check_val("b_active3", bus.ACTIVE_ID, 3);
        base = ticks;
        measure(n); check_val("b_half3a", n, 2);
        measure(n); check_val("b_half3b", n, 2);
        finish_tone("b3", base);
        step();
        check_val("b_busy1", bus.BUSY, 1);
        check_val("b_active1", bus.ACTIVE_ID, 1);
        base = ticks;
        measure(n); check_val("b_half1a", n, 6);
        measure(n); check_val("b_half1b", n, 6);
        finish_tone("b1", base);
        steps(10);
        check_val("b_empty", bus.BUSY, 0);

        // Effect 0 playing when REQ[2] arrives.
        bus.REQ = 4'b0001;
        step();
        step();
        base = ticks;
        steps(3);
        bus.REQ = 4'b0100;
        step();
        step();
`ifdef SFX_PREEMPT_EN
        check_val("c_preempt_id", bus.ACTIVE_ID, 2);
        check_val("c_preempt_audio", bus.AUDIO, 0);
        base = ticks;
        measure(n); check_val("c_half2", n, 4);
        finish_tone("c2", base);
        steps(20);
        check_val("c_no_resume", bus.BUSY, 0);
`else
        check_val("c_keep_id", bus.ACTIVE_ID, 0);
        finish_tone("c0", base);
        step();
        check_val("c_next_id", bus.ACTIVE_ID, 2);
        check_val("c_next_busy", bus.BUSY, 1);
        base = ticks;
        finish_tone("c2", base);
`endif

        // Effect 1 requested three more times while playing; it must replay exactly once.
        bus.REQ = 4'b0010;
        step();
        step();
        base = ticks;
        steps(5);
        bus.REQ = 4'b0010; step();
        steps(3);
        bus.REQ = 4'b0010; step();
        step();
        bus.REQ = 4'b0010; step();
        finish_tone("d1", base);
        step();
        check_val("d_replay_busy", bus.BUSY, 1);
        check_val("d_replay_id", bus.ACTIVE_ID, 1);
        base = ticks;
        finish_tone("d1r", base);
        steps(10);
        check_val("d_once", bus.BUSY, 0);

        // Reset during PLAY of effect 3 with effect 2 pending.
        bus.REQ = 4'b1000;
        step();
        step();
        check_val("e_active3", bus.ACTIVE_ID, 3);
        bus.REQ = 4'b0100;
        step();
        steps(2);
        RESET_N = 1'b0;
        bus.REQ = 4'b0010;
        step();
        check_val("e_rst_audio", bus.AUDIO, 0);
        check_val("e_rst_busy", bus.BUSY, 0);
        check_val("e_rst_active", bus.ACTIVE_ID, 0);
        RESET_N = 1'b1;
        cnt = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (bus.BUSY !== 1'b0) cnt++;
        end
        check_val("e_silent", cnt, 0);

        // REQ[3] arriving on the same edge that grants effect 0.
        bus.REQ = 4'b0001;
        step();
        bus.REQ = 4'b1000;
        step();
        check_val("f_grant0", bus.ACTIVE_ID, 0);
        base = ticks;
`ifdef SFX_PREEMPT_EN
        step();
        check_val("f_preempt3", bus.ACTIVE_ID, 3);
        base = ticks;
        finish_tone("f3", base);
`else
        finish_tone("f0", base);
        step();
        check_val("f_next3", bus.ACTIVE_ID, 3);
        check_val("f_next_busy", bus.BUSY, 1);
        base = ticks;
        finish_tone("f3", base);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sfx_arbiter.md
SFX_ARBITER -- requirements
Module: sfx_arbiter

Interface
REQ-001 Parameter HALF_0, default 16'd40000, meaning tone half-period in CLK cycles for effect 0 (wall bounce, lowest priority).
REQ-002 Parameter HALF_1, default 16'd30000, meaning half-period for effect 1 (paddle hit).
REQ-003 Parameter HALF_2, default 16'd20000, meaning half-period for effect 2 (brick break).
REQ-004 Parameter HALF_3, default 16'd10000, meaning half-period for effect 3 (ball lost, highest priority).
REQ-005 Parameter DUR_FRAMES, default 8'd6, meaning tone length in FRAME_TICK pulses; legal range 1..255.
REQ-006 CLK  input  1  system clock (40 MHz); all logic on its rising edge.
REQ-007 RESET_N  input  1  reset, synchronous and active-low.
REQ-008 FRAME_TICK  input  1  one-cycle pulse per video frame (the renderer's frame-done strobe).
REQ-009 REQ  input  4  one-cycle effect request pulses; bit n requests effect n.
REQ-010 AUDIO  output  1  registered square-wave audio bit.
REQ-011 BUSY  output  1  high in PLAY or GAP.
REQ-012 ACTIVE_ID  output  2  index of the effect currently granted; holds last value in IDLE/GAP.

Function
REQ-013 Each REQ bit set in a cycle SHALL set the matching PENDING bit at that edge; a repeat request for an already pending effect SHALL merge (no counting).
REQ-014 The FSM SHALL have states IDLE, PLAY, GAP; encoding is free.
REQ-015 IDLE with PENDING nonzero SHALL grant the highest-index pending bit at the next edge: state to PLAY, ACTIVE_ID set, that PENDING bit cleared, divider to 0, AUDIO to 0, frame counter to DUR_FRAMES.
REQ-016 Latency: REQ pulse at edge k in IDLE SHALL give BUSY=1 after edge k+1.
REQ-017 In PLAY the 16-bit divider SHALL count 0..HALF_n-1; on reaching HALF_n-1 it SHALL wrap to 0 and AUDIO SHALL toggle, giving period 2*HALF_n cycles.
REQ-018 In PLAY each FRAME_TICK SHALL decrement the frame counter; a FRAME_TICK with counter equal to 1 SHALL move to GAP with AUDIO=0.
REQ-019 GAP SHALL hold AUDIO=0 and return to IDLE on the next FRAME_TICK; pending requests SHALL NOT be granted from GAP.
REQ-020 A request for the active effect during PLAY SHALL set its PENDING bit and replay after GAP.
REQ-021 REQ and grant in the same cycle: the new REQ bit SHALL land in PENDING and SHALL NOT take part in that grant.
REQ-022 Simultaneous REQ on several bits SHALL all be recorded; grants SHALL follow in descending index order, one per IDLE visit.
REQ-023 HALF_n of 0 or 1 SHALL be treated as 1 (AUDIO toggles every cycle).

Reset
REQ-024 RESET_N low at an edge SHALL force state IDLE, PENDING=0, divider=0, frame counter=0, AUDIO=0, BUSY=0, ACTIVE_ID=0, regardless of FRAME_TICK or REQ in that cycle.
REQ-025 Reset asserted mid-PLAY SHALL discard the tone and all pending requests; REQ sampled while RESET_N low SHALL be ignored.

Configuration
REQ-026 Macro SFX_PREEMPT_EN defined: in PLAY, a PENDING bit with index greater than ACTIVE_ID SHALL re-grant at the next edge per REQ-015 (tone restarts, frame counter reloaded), and preemption SHALL win over a simultaneous end-of-tone FRAME_TICK.
REQ-027 Macro SFX_PREEMPT_EN undefined: PLAY SHALL always run to its full DUR_FRAMES; higher requests wait in PENDING.
REQ-028 The preempted effect SHALL NOT be re-queued in either build.

Verification (bench parameters HALF_0..3 = 8,6,4,2; DUR_FRAMES=2; FRAME_TICK every 100 cycles)
REQ-029 Reset, then REQ=4'b0001 one cycle -> BUSY=1 two edges later, ACTIVE_ID=0, AUDIO toggles every 8 cycles, GAP after 2nd FRAME_TICK, IDLE after 3rd.
REQ-030 REQ=4'b1010 in one cycle -> effect 3 plays (AUDIO period 4 cycles), GAP, IDLE, then effect 1 (period 12), PENDING empty at end.
REQ-031 With SFX_PREEMPT_EN: effect 0 playing, REQ[2] pulse -> next edge ACTIVE_ID=2, divider and AUDIO restart at 0, effect 0 never resumes; without macro -> effect 0 finishes, effect 2 plays after GAP.
REQ-032 Effect 1 playing, REQ[1] pulsed three times -> effect 1 replays exactly once after GAP.
REQ-033 RESET_N low for one cycle mid-PLAY with PENDING=4'b0100 -> all outputs reset values next edge, no further tone without new REQ.
REQ-034 REQ[3] coincident with the grant edge of effect 0 (macro undefined) -> effect 0 plays full length, effect 3 follows.
